// File: rtl/cb_portb_wr_seq.sv
// cb_portb_wr_seq: port-B write sequencer for the covariance bank.
// Takes a row-burst request, steers the port-B data mapper (direction select
// and new-landmark half flag), and emits per-bank write enables and
// addresses. Enables and addresses are registered so they line up with the
// mapper's registered data output.
//
// Optional build macro CB_WR_ERR_EN: adds a sticky 'err' output. It flags
// c_valid outside WRITE and over-range row counts; over-range requests are
// clamped to ROW_LEN rows.
module cb_portb_wr_seq #(
  parameter int L       = 4,
  parameter int RSA_DW  = 16,
  parameter int CB_AW   = 10,
  parameter int ROW_LEN = 10,
  localparam int RW     = $clog2(ROW_LEN + 1)
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CB_AW-1:0] req_base,
  input  logic [RW-1:0]    req_rows,
  input  logic [1:0]       req_dir,
  input  logic             req_l_k_0,
  input  logic             c_valid,
  output logic [1:0]       CB_dinb_sel,
  output logic             l_k_0,
  output logic [L-1:0]     CB_web,
  output logic [CB_AW-1:0] CB_addrb,
  output logic             done
`ifdef CB_WR_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  // Lower half of the row belongs to the l_k_0=1 landmark half, upper half
  // to l_k_0=0.
  localparam logic [L-1:0] MASK_LO = L'((1 << (L / 2)) - 1);
  localparam logic [L-1:0] MASK_HI = ~MASK_LO;

  // The lane data width only has to be sane for the bus this block sits on;
  // a zero width would leave the sequencer with nothing to accept.
  localparam logic DW_OK = (RSA_DW > 0);

  logic [1:0]       state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic             lk_q, lk_d;
  logic [RW-1:0]    rows_q, rows_d;
  logic [CB_AW-1:0] anext_q, anext_d;
  logic [L-1:0]     web_q, web_d;
  logic [CB_AW-1:0] addrb_q, addrb_d;
  logic [L-1:0]     wr_mask;
  logic [RW-1:0]    rows_in;
  logic             accept;

  assign accept = (state_q == S_IDLE) && req_valid;

`ifdef CB_WR_ERR_EN
  logic err_q, err_d;
  logic rows_over;

  assign rows_over = (req_rows > RW'(ROW_LEN));
  assign rows_in   = rows_over ? RW'(ROW_LEN) : req_rows;

  // Sticky error: reloaded on each accepted request, then set by stray c_valid.
  always_comb begin
    err_d = err_q;
    if (accept) err_d = rows_over;
    if (c_valid && (state_q != S_WRITE)) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign err = err_q;
`else
  assign rows_in = req_rows;
`endif

  // Write-enable mask for the latched burst direction and landmark half.
  always_comb begin
    wr_mask = '1;
    if (dir_q == DIR_NEW) wr_mask = lk_q ? MASK_LO : MASK_HI;
  end

  // Next-state and datapath update for the burst sequencer.
  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lk_d    = lk_q;
    rows_d  = rows_q;
    anext_d = anext_q;
    addrb_d = addrb_q;
    web_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dir_d   = req_dir;
          lk_d    = req_l_k_0;
          rows_d  = rows_in;
          anext_d = req_base;
          if ((rows_in == '0) || (req_dir == DIR_IDLE)) state_d = S_DONE;
          else                                           state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // A bubble leaves web_d at zero and the address untouched.
        if (c_valid) begin
          web_d   = wr_mask;
          addrb_d = anext_q;
          anext_d = (dir_q == DIR_NEG) ? anext_q - CB_AW'(1)
                                       : anext_q + CB_AW'(1);
          rows_d  = rows_q - RW'(1);
          if (rows_q == RW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_IDLE;
      lk_q    <= 1'b0;
      rows_q  <= '0;
      anext_q <= '0;
      web_q   <= '0;
      addrb_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lk_q    <= lk_d;
      rows_q  <= rows_d;
      anext_q <= anext_d;
      web_q   <= web_d;
      addrb_q <= addrb_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE) && DW_OK;
  assign CB_dinb_sel = ((state_q == S_WRITE) && c_valid) ? dir_q : DIR_IDLE;
  assign l_k_0       = lk_q;
  assign CB_web      = web_q;
  assign CB_addrb    = addrb_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_cb_portb_wr_seq.sv
// Directed bench for cb_portb_wr_seq. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. Expected values are
// hand-computed per cycle.
module tb_cb_portb_wr_seq;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_base;
  logic [3:0] req_rows;
  logic [1:0] req_dir;
  logic       req_l_k_0;
  logic       c_valid;
  logic [1:0] CB_dinb_sel;
  logic       l_k_0;
  logic [3:0] CB_web;
  logic [9:0] CB_addrb;
  logic       done;
`ifdef CB_WR_ERR_EN
  logic       err;
`endif

  int total = 0;
  int bad   = 0;

  cb_portb_wr_seq dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .req_rows   (req_rows),
    .req_dir    (req_dir),
    .req_l_k_0  (req_l_k_0),
    .c_valid    (c_valid),
    .CB_dinb_sel(CB_dinb_sel),
    .l_k_0      (l_k_0),
    .CB_web     (CB_web),
    .CB_addrb   (CB_addrb),
    .done       (done)
`ifdef CB_WR_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One WRITE-side cycle: drive c_valid, sample on the falling edge.
  // e_addr < 0 means the address is not checked this cycle.
  task automatic cyc(input string tag, input logic cv, input logic [1:0] e_sel,
                     input logic [3:0] e_web, input int e_addr,
                     input logic e_done, input logic e_rdy);
    c_valid = cv;
    @(negedge clk);
    check({tag, "_sel"}, 32'(CB_dinb_sel), 32'(e_sel));
    check({tag, "_web"}, 32'(CB_web), 32'(e_web));
    if (e_addr >= 0) check({tag, "_addr"}, 32'(CB_addrb), e_addr);
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_rdy"}, 32'(req_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle in IDLE and confirm it is offered.
  task automatic req(input string tag, input logic [9:0] base, input logic [3:0] rows,
                     input logic [1:0] dir, input logic lk);
    req_valid = 1'b1;
    req_base  = base;
    req_rows  = rows;
    req_dir   = dir;
    req_l_k_0 = lk;
    c_valid   = 1'b0;
    @(negedge clk);
    check({tag, "_req_rdy"}, 32'(req_ready), 32'd1);
    check({tag, "_req_sel"}, 32'(CB_dinb_sel), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    req_valid = 1'b0;
    req_base  = '0;
    req_rows  = '0;
    req_dir   = 2'b00;
    req_l_k_0 = 1'b0;
    c_valid   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_web",  32'(CB_web), 32'd0);
    check("rst_addr", 32'(CB_addrb), 32'd0);
    check("rst_lk",   32'(l_k_0), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdy",  32'(req_ready), 32'd1);
    sys_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: pos burst base=5 rows=3, c_valid three cycles back-to-back
    req("t1", 10'd5, 4'd3, 2'b01, 1'b0);
    cyc("t1_c1", 1'b1, 2'b01, 4'b0000, -1, 1'b0, 1'b0);
    cyc("t1_c2", 1'b1, 2'b01, 4'b1111,  5, 1'b0, 1'b0);
    cyc("t1_c3", 1'b1, 2'b01, 4'b1111,  6, 1'b0, 1'b0);
    cyc("t1_dr", 1'b0, 2'b00, 4'b1111,  7, 1'b0, 1'b0);
    cyc("t1_dn", 1'b0, 2'b00, 4'b0000,  7, 1'b1, 1'b0);
    cyc("t1_id", 1'b0, 2'b00, 4'b0000,  7, 1'b0, 1'b1);

    // T2: neg burst base=1 rows=3 wraps 1,0,1023
    req("t2", 10'd1, 4'd3, 2'b10, 1'b0);
    cyc("t2_c1", 1'b1, 2'b10, 4'b0000, -1,   1'b0, 1'b0);
    cyc("t2_c2", 1'b1, 2'b10, 4'b1111,  1,   1'b0, 1'b0);
    cyc("t2_c3", 1'b1, 2'b10, 4'b1111,  0,   1'b0, 1'b0);
    cyc("t2_dr", 1'b0, 2'b00, 4'b1111,  1023, 1'b0, 1'b0);
    cyc("t2_dn", 1'b0, 2'b00, 4'b0000,  1023, 1'b1, 1'b0);

    // T3a: new burst l_k_0=1 rows=2 -> lower half enables
    req("t3a", 10'd40, 4'd2, 2'b11, 1'b1);
    check("t3a_lk", 32'(l_k_0), 32'd1);
    cyc("t3a_c1", 1'b1, 2'b11, 4'b0000, -1, 1'b0, 1'b0);
    cyc("t3a_c2", 1'b1, 2'b11, 4'b0011, 40, 1'b0, 1'b0);
    cyc("t3a_dr", 1'b0, 2'b00, 4'b0011, 41, 1'b0, 1'b0);
    cyc("t3a_dn", 1'b0, 2'b00, 4'b0000, 41, 1'b1, 1'b0);

    // T3b: new burst l_k_0=0 rows=2 -> upper half enables
    req("t3b", 10'd20, 4'd2, 2'b11, 1'b0);
    check("t3b_lk", 32'(l_k_0), 32'd0);
    cyc("t3b_c1", 1'b1, 2'b11, 4'b0000, -1, 1'b0, 1'b0);
    cyc("t3b_c2", 1'b1, 2'b11, 4'b1100, 20, 1'b0, 1'b0);
    cyc("t3b_dr", 1'b0, 2'b00, 4'b1100, 21, 1'b0, 1'b0);
    cyc("t3b_dn", 1'b0, 2'b00, 4'b0000, 21, 1'b1, 1'b0);

    // T4: pos rows=4 with c_valid 1,0,0,1,1,0,1 (bubbles hold address)
    req("t4", 10'd100, 4'd4, 2'b01, 1'b0);
    cyc("t4_c1", 1'b1, 2'b01, 4'b0000, -1,  1'b0, 1'b0);
    cyc("t4_c2", 1'b0, 2'b00, 4'b1111, 100, 1'b0, 1'b0);
    cyc("t4_c3", 1'b0, 2'b00, 4'b0000, 100, 1'b0, 1'b0);
    cyc("t4_c4", 1'b1, 2'b01, 4'b0000, 100, 1'b0, 1'b0);
    cyc("t4_c5", 1'b1, 2'b01, 4'b1111, 101, 1'b0, 1'b0);
    cyc("t4_c6", 1'b0, 2'b00, 4'b1111, 102, 1'b0, 1'b0);
    cyc("t4_c7", 1'b1, 2'b01, 4'b0000, 102, 1'b0, 1'b0);
    cyc("t4_dr", 1'b0, 2'b00, 4'b1111, 103, 1'b0, 1'b0);
    cyc("t4_dn", 1'b0, 2'b00, 4'b0000, 103, 1'b1, 1'b0);

    // T5: rows=0 goes straight to DONE; a request during DONE is refused
    req("t5", 10'd50, 4'd0, 2'b01, 1'b0);
    req_valid = 1'b1;
    req_rows  = 4'd2;
    cyc("t5_dn", 1'b0, 2'b00, 4'b0000, 103, 1'b1, 1'b0);
    req_valid = 1'b0;
    cyc("t5_id", 1'b0, 2'b00, 4'b0000, 103, 1'b0, 1'b1);

    // T5b: dir=00 with nonzero rows also skips writing
    req("t5b", 10'd60, 4'd3, 2'b00, 1'b0);
    cyc("t5b_dn", 1'b1, 2'b00, 4'b0000, 103, 1'b1, 1'b0);
    cyc("t5b_id", 1'b0, 2'b00, 4'b0000, 103, 1'b0, 1'b1);

    // T6: reset asserted during the second row of a 5-row burst
    req("t6", 10'd200, 4'd5, 2'b01, 1'b0);
    cyc("t6_c1", 1'b1, 2'b01, 4'b0000, -1, 1'b0, 1'b0);
    c_valid = 1'b1;
    @(negedge clk);
    check("t6_c2_web",  32'(CB_web), 32'hF);
    check("t6_c2_addr", 32'(CB_addrb), 32'd200);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_web",  32'(CB_web), 32'd0);
    check("t6_rst_addr", 32'(CB_addrb), 32'd0);
    check("t6_rst_sel",  32'(CB_dinb_sel), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_lk",   32'(l_k_0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("t6_p1", 1'b1, 2'b00, 4'b0000, 0, 1'b0, 1'b1);
    cyc("t6_p2", 1'b1, 2'b00, 4'b0000, 0, 1'b0, 1'b1);
    cyc("t6_p3", 1'b0, 2'b00, 4'b0000, 0, 1'b0, 1'b1);

`ifdef CB_WR_ERR_EN
    // Stray c_valid in IDLE above sets err; an accepted request clears it
    check("t7_err_set", 32'(err), 32'd1);
    req("t7", 10'd0, 4'd0, 2'b01, 1'b0);
    check("t7_err_clr", 32'(err), 32'd0);
    cyc("t7_dn", 1'b0, 2'b00, 4'b0000, 0, 1'b1, 1'b0);
    // Over-range row count sets err at acceptance
    req("t8", 10'd0, 4'd15, 2'b00, 1'b0);
    check("t8_err_over", 32'(err), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cb_portb_wr_seq.md
Name: cb_portb_wr_seq

Overview:
- Write-side sequencer directly downstream of the covariance-bank port-B data mapper.
- Accepts a row-burst request, drives the mapper's direction select and new-landmark half flag, and generates port-B write enables and addresses.
- Enables and addresses are registered one cycle later so they line up with the mapper's registered data output.
- Sits between the systolic-array output handshake and the covariance BRAM port B.

Parameters:
- L, 4, number of lanes/banks in a CB row (one write-enable bit each)
- RSA_DW, 16, lane data width (sizes nothing here; kept for bus-width consistency checks)
- CB_AW, 10, port-B address width
- ROW_LEN, 10, max rows per burst; req_rows width = clog2(ROW_LEN+1)

Ports:
- clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  burst request valid
- req_ready  out  1  high only in IDLE
- req_base  in  CB_AW  first row address
- req_rows  in  clog2(ROW_LEN+1)  rows in burst (0..ROW_LEN)
- req_dir  in  2  00 idle, 01 pos, 10 neg, 11 new
- req_l_k_0  in  1  new-landmark half select
- c_valid  in  1  systolic array presents one row this cycle
- CB_dinb_sel  out  2  to mapper, combinational
- l_k_0  out  1  to mapper, registered copy of req_l_k_0
- CB_web  out  L  per-bank write enable, registered
- CB_addrb  out  CB_AW  port-B address, registered
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE; CB_web=0, CB_addrb=0, l_k_0=0, done=0, counters 0. Reset mid-burst aborts the burst with no further writes.
- States: IDLE, WRITE, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch base, rows, dir and l_k_0; go to WRITE.
  - If rows==0 or dir==00, go straight to DONE with no writes.
- WRITE:
  - CB_dinb_sel = latched dir when c_valid=1, else 00.
  - Each c_valid cycle (cycle t) issues one row and decrements the remaining count.
  - CB_web/CB_addrb are updated at edge t+1, aligned with the mapper's data.
  - c_valid=0 cycles insert bubbles: CB_web=0 the next cycle, address held.
  - After the last row issues, go to DRAIN.
- DRAIN: one cycle. CB_dinb_sel=00; the final write is visible on CB_web/CB_addrb this cycle. Go to DONE.
- DONE: done=1 for one cycle, CB_web=0; go to IDLE. req_ready returns the following cycle.
- Address sequence:
  - Row k of the burst uses base+k for pos and new, base-k for neg.
  - Arithmetic is modulo 2^CB_AW, so wrap-around is legal and silent.
- Enable mask:
  - pos and neg: all L bits.
  - new with l_k_0=1: bits 0 and 1.
  - new with l_k_0=0: bits 2 and 3.
- Outside WRITE:
  - CB_dinb_sel=00 always.
  - c_valid is ignored outside WRITE, and req_valid is ignored outside IDLE.
  - A request arriving in the same cycle as done is not accepted.

Optional Feature:
- Macro CB_WR_ERR_EN.
- When defined, adds output err (1 bit, sticky), cleared to 0 on reset and on each accepted request.
- err is set when c_valid=1 in any state other than WRITE, or when req_rows>ROW_LEN at acceptance. An over-range request is clamped to ROW_LEN rows.
- When undefined: no err port, and no clamping (req_rows>ROW_LEN is undefined usage).

Test Plan:
- pos burst, base=5, rows=3, c_valid high 3 cycles:
  - CB_dinb_sel=01 for 3 cycles.
  - CB_web=1111 at addrs 5,6,7, each one cycle after its c_valid.
  - done exactly 2 cycles after the last c_valid.
- neg burst, base=1, rows=3: addrs 1, 0, 1023 (wrap), CB_web=1111, CB_dinb_sel=10.
- new burst, l_k_0=1 then l_k_0=0, rows=2 each:
  - CB_web=0011 then 1100.
  - l_k_0 output matches the request during each burst.
- pos rows=4 with c_valid pattern 1,0,0,1,1,0,1:
  - exactly 4 writes at base..base+3.
  - CB_web=0 during bubbles, address held during bubbles.
- rows=0 request: no CB_web activity, done 1 cycle after acceptance; req_ready low until the cycle after done.
- sys_rst_n pulled low during the second row of a 5-row burst:
  - all outputs 0 immediately.
  - no later writes; req_ready=1 after release.
  - With CB_WR_ERR_EN defined, c_valid while in IDLE sets err.
